span_writer: RTL

SPAN_WRITER -- requirements
Module: span_writer

---
 rtl/span_writer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/span_writer.sv
// span_writer -- rasterises horizontal spans into a frame buffer and clears
// the buffer on request.
//
// A span command (row y, inclusive columns x0..x1, colour, depth) is written
// one pixel at a time. Each written pixel is {z, colour}, with z in the MSBs.
// A new-frame request fills the whole buffer with {all-ones z, zero colour}
// in row-major order, then pulses o_clear_done.
//
// Optional feature, macro SPAN_WRITER_ZTEST_EN:
//   defined   - each pixel takes a read cycle (SPAN_RD) and then a write cycle
//               (SPAN_WR). The write happens only if the span depth is
//               strictly nearer (smaller) than the stored depth. A span of n
//               pixels takes 2n cycles.
//   undefined - each pixel is written unconditionally in one cycle. A span of
//               n pixels takes n cycles, and i_read_pixel_data is ignored.
//
// Ports:
//   i_clk, i_srst          clock, synchronous active-high reset
//   i_new_frame            one-cycle request to clear the buffer
//   i_span_valid/_ready    span command handshake (ready is combinational)
//   i_span_y/x0/x1         span row, first and last column (both inclusive)
//   i_span_color/z         span colour and depth (smaller z is nearer)
//   o_vert/horiz_write_addr  buffer address, shared by reads and writes
//   o_write_en             buffer write strobe
//   o_write_pixel_data     {z, colour}
//   i_read_pixel_data      buffer read data, one cycle after the address
//   o_raster_in_progress   busy, or a clear is still pending
//   o_clear_done           one-cycle pulse after the last clear write
module span_writer #(
  parameter int HORIZ_RESOLUTION = 640,
  parameter int VERT_RESOLUTION  = 480,
  parameter int COLOR_DEPTH      = 12,
  parameter int Z_DEPTH          = 2,
  localparam int X = $clog2(HORIZ_RESOLUTION),
  localparam int Y = $clog2(VERT_RESOLUTION),
  localparam int W = COLOR_DEPTH + Z_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_new_frame,
  input  logic                   i_span_valid,
  output logic                   o_span_ready,
  input  logic [Y-1:0]           i_span_y,
  input  logic [X-1:0]           i_span_x0,
  input  logic [X-1:0]           i_span_x1,
  input  logic [COLOR_DEPTH-1:0] i_span_color,
  input  logic [Z_DEPTH-1:0]     i_span_z,
  output logic [Y-1:0]           o_vert_write_addr,
  output logic [X-1:0]           o_horiz_write_addr,
  output logic                   o_write_en,
  output logic [W-1:0]           o_write_pixel_data,
  input  logic [W-1:0]           i_read_pixel_data,
  output logic                   o_raster_in_progress,
  output logic                   o_clear_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, SPAN_RD, SPAN_WR} state_t;

  localparam logic [X-1:0] X_LAST     = X'(HORIZ_RESOLUTION - 1);
  localparam logic [Y-1:0] Y_LAST     = Y'(VERT_RESOLUTION - 1);
  localparam logic [W-1:0] CLEAR_WORD = {{Z_DEPTH{1'b1}}, {COLOR_DEPTH{1'b0}}};

  state_t       state;
  logic         clr_pend;   // clear requested while a span was running
  logic [X-1:0] sp_x1;      // clamped last column of the active span
  logic         we_q;
  logic         done_q;

  logic [X-1:0] x1_clamp;
  logic         span_ok;
  logic         accept;
  logic         clear_now;  // a clear is requested or still pending

  // Clamping x1 to the last column means x0 <= x1_clamp already implies that
  // x0 is on screen, so no separate x0 range test is needed.
  assign x1_clamp  = (i_span_x1 > X_LAST) ? X_LAST : i_span_x1;
  assign span_ok   = (i_span_x0 <= x1_clamp) && (i_span_y <= Y_LAST);

  assign o_span_ready = !i_srst && (state == IDLE) && !clr_pend && !i_new_frame;
  assign accept       = i_span_valid && o_span_ready;
  assign clear_now    = clr_pend || i_new_frame;

  assign o_raster_in_progress = (state != IDLE) || clr_pend;
  assign o_clear_done         = done_q;

  // Only the depth field of the read data matters, and only when the depth
  // test is built in.
  logic unused_rd;
  assign unused_rd = ^i_read_pixel_data;

`ifdef SPAN_WRITER_ZTEST_EN
  // Read data belongs to the address driven in the preceding SPAN_RD cycle,
  // so the write decision has to be combinational during SPAN_WR.
  logic z_pass;
  assign z_pass     = o_write_pixel_data[W-1 -: Z_DEPTH] < i_read_pixel_data[W-1 -: Z_DEPTH];
  assign o_write_en = we_q || ((state == SPAN_WR) && z_pass);
`else
  assign o_write_en = we_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state              <= IDLE;
      clr_pend           <= 1'b0;
      sp_x1              <= '0;
      we_q               <= 1'b0;
      done_q             <= 1'b0;
      o_vert_write_addr  <= '0;
      o_horiz_write_addr <= '0;
      o_write_pixel_data <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_now) begin
            // A new frame beats a span offered in the same cycle (ready is low).
            state              <= CLEAR;
            clr_pend           <= 1'b0;
            o_vert_write_addr  <= '0;
            o_horiz_write_addr <= '0;
            o_write_pixel_data <= CLEAR_WORD;
            we_q               <= 1'b1;
          end else if (accept && span_ok) begin
            // Off-screen or empty spans are still accepted; they just never
            // leave IDLE.
            sp_x1              <= x1_clamp;
            o_vert_write_addr  <= i_span_y;
            o_horiz_write_addr <= i_span_x0;
            o_write_pixel_data <= {i_span_z, i_span_color};
`ifdef SPAN_WRITER_ZTEST_EN
            state              <= SPAN_RD;
            we_q               <= 1'b0;
`else
            state              <= SPAN_WR;
            we_q               <= 1'b1;
`endif
          end
        end

        CLEAR: begin
          // Requests that arrive during a clear are ignored.
          if (o_horiz_write_addr == X_LAST) begin
            if (o_vert_write_addr == Y_LAST) begin
              state  <= IDLE;
              we_q   <= 1'b0;
              done_q <= 1'b1;
            end else begin
              o_horiz_write_addr <= '0;
              o_vert_write_addr  <= o_vert_write_addr + 1'b1;
            end
          end else begin
            o_horiz_write_addr <= o_horiz_write_addr + 1'b1;
          end
        end

`ifdef SPAN_WRITER_ZTEST_EN
        SPAN_RD: begin
          if (i_new_frame) clr_pend <= 1'b1;
          state <= SPAN_WR;
        end
`endif

        SPAN_WR: begin
          if (o_horiz_write_addr == sp_x1) begin
            if (clear_now) begin
              // Go straight into the clear. A request in this same cycle is
              // merged with any request already pending.
              state              <= CLEAR;
              clr_pend           <= 1'b0;
              o_vert_write_addr  <= '0;
              o_horiz_write_addr <= '0;
              o_write_pixel_data <= CLEAR_WORD;
              we_q               <= 1'b1;
            end else begin
              state <= IDLE;
              we_q  <= 1'b0;
            end
          end else begin
            if (i_new_frame) clr_pend <= 1'b1;
            o_horiz_write_addr <= o_horiz_write_addr + 1'b1;
`ifdef SPAN_WRITER_ZTEST_EN
            state <= SPAN_RD;
`endif
          end
        end

        default: begin
          state <= IDLE;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
